// File: rtl/cla_pkg.sv
// Shared definitions for the nibble-serial carry-lookahead adder.
package cla_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/cla_nibble_serial_adder_if.sv
// Operand/result valid-ready bundle between the producer/consumer and the adder.
interface cla_nibble_serial_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             P;
    logic             G;
    logic             ovf;

    modport master (
        output in_valid, a, b, c_in, out_ready,
        input  in_ready, out_valid, sum, c_out, P, G, ovf
    );

    modport slave (
        input  in_valid, a, b, c_in, out_ready,
        output in_ready, out_valid, sum, c_out, P, G, ovf
    );
endinterface

// File: rtl/CLA_4_bit_Augmented.sv
// Combinational 4-bit carry-lookahead slice with group propagate/generate outputs.
module CLA_4_bit_Augmented (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out,
    output logic       P,
    output logic       G
);
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;

    assign p = a ^ b;
    assign g = a & b;

    assign c[0] = c_in;
    assign c[1] = g[0] | (p[0] & c_in);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);

    assign sum   = p ^ c;
    assign P     = &p;
    assign G     = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign c_out = G | (P & c_in);
endmodule

// File: rtl/cla_nibble_serial_adder.sv
// WIDTH-bit adder that reuses one 4-bit CLA slice, one nibble per cycle, LSB first,
// with valid/ready handshakes on operands and result.
module cla_nibble_serial_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    cla_nibble_serial_adder_if.slave bus
);
    localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
    localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < NIBBLE_W)) begin : g_width_check
        $error("cla_nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic               p_acc_q, p_acc_d;
    logic               g_acc_q, g_acc_d;
    logic [WIDTH-1:0]   sum_acc_q, sum_acc_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               c_out_q, c_out_d;
    logic               p_q, p_d;
    logic               g_q, g_d;
    logic               ovf_q, ovf_d;

    logic [NIBBLE_W-1:0] slice_a;
    logic [NIBBLE_W-1:0] slice_b;
    logic [NIBBLE_W-1:0] slice_sum;
    logic                slice_c;
    logic                slice_p;
    logic                slice_g;
    logic [WIDTH-1:0]    sum_full;
    logic                p_next;
    logic                g_next;

    assign slice_a = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
    assign slice_b = b_q[NIBBLE_W*idx_q +: NIBBLE_W];

    CLA_4_bit_Augmented u_slice (
        .a     (slice_a),
        .b     (slice_b),
        .c_in  (carry_q),
        .sum   (slice_sum),
        .c_out (slice_c),
        .P     (slice_p),
        .G     (slice_g)
    );

    // Next-state, datapath sequencing and registered-output values.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        p_acc_d     = p_acc_q;
        g_acc_d     = g_acc_q;
        sum_acc_d   = sum_acc_q;
        in_ready_d  = 1'b0;
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        c_out_d     = c_out_q;
        p_d         = p_q;
        g_d         = g_q;
        ovf_d       = ovf_q;

        sum_full = sum_acc_q;
        sum_full[NIBBLE_W*idx_q +: NIBBLE_W] = slice_sum;
        p_next = p_acc_q & slice_p;
        g_next = slice_g | (slice_p & g_acc_q);

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.c_in;
                    idx_d   = '0;
                    p_acc_d = 1'b1;
                    g_acc_d = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_acc_d = sum_full;
                carry_d   = slice_c;
                p_acc_d   = p_next;
                g_acc_d   = g_next;
                if (idx_q == IDX_W'(NIBBLES - 1)) begin
                    sum_d       = sum_full;
                    c_out_d     = slice_c;
                    p_d         = p_next;
                    g_d         = g_next;
                    ovf_d       = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_full[WIDTH-1] != a_q[WIDTH-1]);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            p_acc_q     <= 1'b0;
            g_acc_q     <= 1'b0;
            sum_acc_q   <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            c_out_q     <= 1'b0;
            p_q         <= 1'b0;
            g_q         <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            p_acc_q     <= p_acc_d;
            g_acc_q     <= g_acc_d;
            sum_acc_q   <= sum_acc_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            c_out_q     <= c_out_d;
            p_q         <= p_d;
            g_q         <= g_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.c_out     = c_out_q;
    assign bus.P         = p_q;
    assign bus.G         = g_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Directed bench for cla_nibble_serial_adder at WIDTH=16 with hand-computed results.
module tb_cla_nibble_serial_adder;
    localparam int unsigned WIDTH   = 16;
    localparam int unsigned NIBBLES = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    cla_nibble_serial_adder_if #(.WIDTH(WIDTH)) bus ();

    cla_nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_in_ready(input string tag);
        int n;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic wait_out_valid(input string tag);
        int n;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(NIBBLES));
    endtask

    // Full transaction with out_ready held high; checks latency, result and handshake.
    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic cv, input logic [15:0] es, input logic ec,
                          input logic ep, input logic eg, input logic eo, input bit check_pg);
        wait_in_ready(tag);
        bus.a         = av;
        bus.b         = bv;
        bus.c_in      = cv;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = ~av;
        bus.b        = ~bv;
        bus.c_in     = ~cv;
        chk({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
        wait_out_valid(tag);
        chk({tag, "_sum"}, 32'(bus.sum), 32'(es));
        chk({tag, "_cout"}, 32'(bus.c_out), 32'(ec));
        chk({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
        if (check_pg) begin
            chk({tag, "_P"}, 32'(bus.P), 32'(ep));
            chk({tag, "_G"}, 32'(bus.G), 32'(eg));
        end
        @(negedge clk);
        chk({tag, "_ovalid_drop"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ov_count;
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.c_in      = 1'b0;
        bus.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);
        chk("rst_flags", 32'({bus.c_out, bus.P, bus.G, bus.ovf}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        run_op("ffff_p1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        run_op("1234_4321", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op("prop_c0", 16'h00FF, 16'hFF00, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Reset lands on the second RUN edge of an in-flight add.
        wait_in_ready("rst_mid");
        bus.a         = 16'h0123;
        bus.b         = 16'h0456;
        bus.c_in      = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_mid_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_mid_sum", 32'(bus.sum), 32'd0);
        chk("rst_mid_flags", 32'({bus.c_out, bus.P, bus.G, bus.ovf}), 32'd0);
        ov_count = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_valid) ov_count++;
        end
        chk("rst_mid_no_result", 32'(ov_count), 32'd0);
        run_op("after_rst", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        run_op("prop_c1", 16'h00FF, 16'hFF00, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        run_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op("ovf_neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // Backpressure: result must hold and new operands must be refused.
        wait_in_ready("bp");
        bus.a         = 16'h0005;
        bus.b         = 16'h000A;
        bus.c_in      = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_out_valid("bp");
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = 16'h1111;
            bus.b        = 16'h2222;
            @(negedge clk);
            chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_hold_sum", 32'(bus.sum), 32'h000F);
            chk("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        chk("bp_keep_sum", 32'(bus.sum), 32'h000F);
        run_op("post_bp", 16'h0010, 16'h0020, 1'b0, 16'h0030, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
